// File: rtl/uart_rx_cfg.sv
// Purpose: oversampling UART receiver with configurable data width, parity and stop bits.
// Latency: valid_rx follows the final stop-bit vote by one clk, about 2 clk of sync plus mid-stop.
// Backpressure: none; valid_rx is a one-clk strobe and the consumer must take rx_data then.
module uart_rx_cfg #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 valid_rx,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int DIV_RAW    = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int SAMPLE_DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW         = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int OW         = $clog2(OVERSAMPLE);
    localparam int M          = OVERSAMPLE / 2;

    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] OS_S0     = OW'(M - 1);
    localparam logic [OW-1:0] OS_S1     = OW'(M);
    localparam logic [OW-1:0] OS_VOTE   = OW'(M + 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rxs;
    logic [TW-1:0]        tick_cnt;
    logic                 tick;
    logic [OW-1:0]        os_cnt, os_nxt;
    logic [3:0]           bit_cnt, bit_nxt;
    logic                 s0, s1;
    logic                 vote, vote_tick;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic                 perr, perr_nxt;
    logic                 ferr, ferr_nxt;
    logic                 allz, allz_nxt;
    logic                 done_nxt;
    logic                 par_exp;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rxs     <= rx_meta;
        end
    end

    // Free-running oversample tick divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Capture the two early samples around mid-bit for the majority vote.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else if (tick && state != IDLE) begin
            if (os_cnt == OS_S0) s0 <= rxs;
            if (os_cnt == OS_S1) s1 <= rxs;
        end
    end

    assign vote      = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    assign vote_tick = tick && (os_cnt == OS_VOTE);
    assign par_exp   = (PARITY_MODE == 1) ? ~^shift : ^shift;

    // State, counter and frame-accumulator registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            os_cnt  <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            allz    <= 1'b1;
        end else begin
            state   <= state_nxt;
            os_cnt  <= os_nxt;
            bit_cnt <= bit_nxt;
            shift   <= shift_nxt;
            perr    <= perr_nxt;
            ferr    <= ferr_nxt;
            allz    <= allz_nxt;
        end
    end

    // Next-state logic: everything advances only on oversample ticks.
    always_comb begin
        state_nxt = state;
        os_nxt    = os_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        perr_nxt  = perr;
        ferr_nxt  = ferr;
        allz_nxt  = allz;
        done_nxt  = 1'b0;

        if (tick) begin
            if (state != IDLE && state != WAIT_HIGH) begin
                os_nxt = (os_cnt == OS_LAST) ? '0 : os_cnt + OW'(1);
            end

            case (state)
                IDLE: begin
                    os_nxt   = '0;
                    bit_nxt  = '0;
                    perr_nxt = 1'b0;
                    ferr_nxt = 1'b0;
                    allz_nxt = 1'b1;
                    if (!rxs) state_nxt = START;
                end

                START: begin
                    if (vote_tick && vote) begin
                        // Low pulse too short to be a start bit.
                        state_nxt = IDLE;
                        os_nxt    = '0;
                    end else if (os_cnt == OS_LAST) begin
                        state_nxt = DATA;
                        bit_nxt   = '0;
                    end
                end

                DATA: begin
                    if (vote_tick) begin
                        shift_nxt = {vote, shift[DATA_BITS-1:1]};
                        allz_nxt  = allz & ~vote;
                    end
                    if (os_cnt == OS_LAST) begin
                        if (bit_cnt == DATA_LAST) begin
                            state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
                            bit_nxt   = '0;
                        end else begin
                            bit_nxt = bit_cnt + 4'd1;
                        end
                    end
                end

                PARITY: begin
                    if (vote_tick) begin
                        perr_nxt = vote ^ par_exp;
                        allz_nxt = allz & ~vote;
                    end
                    if (os_cnt == OS_LAST) begin
                        state_nxt = STOP;
                        bit_nxt   = '0;
                    end
                end

                STOP: begin
                    if (vote_tick) begin
                        ferr_nxt = ferr | ~vote;
                        allz_nxt = allz & ~vote;
                        if (bit_cnt == STOP_LAST) begin
                            // End at mid-stop so a back-to-back start edge is caught.
                            done_nxt  = 1'b1;
                            state_nxt = vote ? IDLE : WAIT_HIGH;
                            os_nxt    = '0;
                        end
                    end else if (os_cnt == OS_LAST) begin
                        bit_nxt = bit_cnt + 4'd1;
                    end
                end

                WAIT_HIGH: begin
                    // A held-low line yields one frame; wait for it to recover.
                    os_nxt = '0;
                    if (rxs) state_nxt = IDLE;
                end

                default: begin
                    state_nxt = IDLE;
                    os_nxt    = '0;
                end
            endcase
        end
    end

    // Publish word and flags together with the valid strobe; hold until next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data    <= '0;
            valid_rx   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            valid_rx <= done_nxt;
            if (done_nxt) begin
                rx_data    <= shift_nxt;
                parity_err <= (PARITY_MODE != 0) ? perr_nxt : 1'b0;
                frame_err  <= ferr_nxt;
                break_det  <= allz_nxt;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three receivers (8N1, 7E1, 8N2) at 16 clk per bit.
// Expected frames are queued as they are driven and compared on valid_rx.
// Line stimulus and output sampling both happen on the falling clock edge.
module tb_uart_rx_cfg;

    localparam int BIT = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;

    logic [7:0] rx_data_a, rx_data_c;
    logic [6:0] rx_data_b;
    logic valid_a, perr_a, ferr_a, brk_a, busy_a;
    logic valid_b, perr_b, ferr_b, brk_b, busy_b;
    logic valid_c, perr_c, ferr_c, brk_c, busy_c;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    exp_t q_a[$], q_b[$], q_c[$];
    exp_t e_a, e_b, e_c;

    int n_vec = 0;
    int n_bad = 0;
    int n_val_a = 0, n_val_b = 0, n_val_c = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_a (
        .clk(clk), .reset(reset), .RxD(rxd_a), .rx_data(rx_data_a), .valid_rx(valid_a),
        .parity_err(perr_a), .frame_err(ferr_a), .break_det(brk_a), .busy(busy_a));

    uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                  .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) u_b (
        .clk(clk), .reset(reset), .RxD(rxd_b), .rx_data(rx_data_b), .valid_rx(valid_b),
        .parity_err(perr_b), .frame_err(ferr_b), .break_det(brk_b), .busy(busy_b));

    uart_rx_cfg #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVERSAMPLE(16),
                  .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_c (
        .clk(clk), .reset(reset), .RxD(rxd_c), .rx_data(rx_data_c), .valid_rx(valid_c),
        .parity_err(perr_c), .frame_err(ferr_c), .break_det(brk_c), .busy(busy_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_line(input int inst, input logic v);
        case (inst)
            0:       rxd_a = v;
            1:       rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    // Drive a level for n clocks, staying aligned to the falling edge.
    task automatic hold(input int inst, input logic v, input int n);
        set_line(inst, v);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int inst, input exp_t e);
        case (inst)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic send_frame(input int inst, input logic [8:0] d, input int nbits,
                              input int has_par, input logic pbit, input int nstop,
                              input logic st1, input logic st2, input logic push);
        logic [8:0] m;
        exp_t e;
        m = d & ((9'd1 << nbits) - 9'd1);
        e.data = m;
        e.perr = (has_par != 0) ? (pbit ^ (^m)) : 1'b0;
        e.ferr = !st1 || (nstop == 2 && !st2);
        e.brk  = (m == 9'd0) && (has_par == 0 || !pbit) && !st1 && (nstop < 2 || !st2);
        if (push) push_exp(inst, e);
        hold(inst, 1'b0, BIT);
        for (int i = 0; i < nbits; i++) hold(inst, d[i], BIT);
        if (has_par != 0) hold(inst, pbit, BIT);
        hold(inst, st1, BIT);
        if (nstop == 2) hold(inst, st2, BIT);
    endtask

    // Scoreboard monitors: one per receiver.
    always @(negedge clk) begin
        if (valid_a) begin
            n_val_a++;
            if (q_a.size() == 0) check("a_unexpected_valid", q_a.size(), 1);
            else begin
                e_a = q_a.pop_front();
                check("a_data", rx_data_a, e_a.data);
                check("a_perr", perr_a, e_a.perr);
                check("a_ferr", ferr_a, e_a.ferr);
                check("a_brk", brk_a, e_a.brk);
            end
        end
    end

    always @(negedge clk) begin
        if (valid_b) begin
            n_val_b++;
            if (q_b.size() == 0) check("b_unexpected_valid", q_b.size(), 1);
            else begin
                e_b = q_b.pop_front();
                check("b_data", rx_data_b, e_b.data);
                check("b_perr", perr_b, e_b.perr);
                check("b_ferr", ferr_b, e_b.ferr);
                check("b_brk", brk_b, e_b.brk);
            end
        end
    end

    always @(negedge clk) begin
        if (valid_c) begin
            n_val_c++;
            if (q_c.size() == 0) check("c_unexpected_valid", q_c.size(), 1);
            else begin
                e_c = q_c.pop_front();
                check("c_data", rx_data_c, e_c.data);
                check("c_perr", perr_c, e_c.perr);
                check("c_ferr", ferr_c, e_c.ferr);
                check("c_brk", brk_c, e_c.brk);
            end
        end
    end

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, gap, t, w;
        logic seen_busy;
        exp_t ez;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_data", rx_data_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_flags", {perr_a, ferr_a, brk_a}, 0);
        check("rst_busy", busy_a, 0);
        reset = 1'b0;
        repeat (2 * BIT) @(negedge clk);

        // 1: back-to-back 8N1 frames; busy gap between them under one bit.
        gap = 0;
        fork
            begin
                send_frame(0, 9'hA5, 8, 0, 1'b0, 1, 1'b1, 1'b1, 1'b1);
                send_frame(0, 9'h3C, 8, 0, 1'b0, 1, 1'b1, 1'b1, 1'b1);
            end
            begin
                base = n_val_a;
                t = 0;
                while (n_val_a == base && t < 400) begin @(negedge clk); t++; end
                while (!busy_a && gap < 40) begin gap++; @(negedge clk); end
            end
        join
        hold(0, 1'b1, 2 * BIT);
        check("a1_gap_ok", (gap > 0 && gap < 16), 1);
        check("a1_count", n_val_a, 2);

        // 2: 7E1 with correct, then wrong, parity.
        send_frame(1, 9'h55, 7, 1, 1'b0, 1, 1'b1, 1'b1, 1'b1);
        hold(1, 1'b1, 2 * BIT);
        send_frame(1, 9'h55, 7, 1, 1'b1, 1, 1'b1, 1'b1, 1'b1);
        hold(1, 1'b1, 2 * BIT);
        check("b2_count", n_val_b, 2);

        // 3: 8N2 with second stop low; receiver waits for the line to go high.
        base = n_val_c;
        send_frame(2, 9'h81, 8, 0, 1'b0, 2, 1'b1, 1'b0, 1'b1);
        hold(2, 1'b0, 2 * BIT);
        check("c3_wait_busy", busy_c, 1);
        check("c3_one_frame", n_val_c - base, 1);
        hold(2, 1'b1, 2 * BIT);
        check("c3_idle_again", busy_c, 0);
        send_frame(2, 9'hFF, 8, 0, 1'b0, 2, 1'b1, 1'b1, 1'b1);
        hold(2, 1'b1, 2 * BIT);
        check("c3_count", n_val_c - base, 2);

        // 4a: 4-clk low pulse on idle line is rejected as a false start.
        base = n_val_a;
        seen_busy = 1'b0;
        set_line(0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy_a) seen_busy = 1'b1;
        end
        set_line(0, 1'b1);
        w = 0;
        while (busy_a && w < 20) begin
            seen_busy = 1'b1;
            @(negedge clk);
            w++;
        end
        check("a4_busy_seen", seen_busy, 1);
        check("a4_busy_drop_le10", (w <= 10), 1);
        hold(0, 1'b1, 2 * BIT);
        check("a4_no_valid", n_val_a - base, 0);

        // 4b: one-clk glitch in the middle of data bit 3 of 0x00.
        ez = '0;
        push_exp(0, ez);
        hold(0, 1'b0, BIT + 3 * BIT + 9);
        hold(0, 1'b1, 1);
        hold(0, 1'b0, 6 + 4 * BIT);
        hold(0, 1'b1, 3 * BIT);

        // 5: 40-bit break gives exactly one frame, then nothing until high.
        base = n_val_a;
        ez.data = '0;
        ez.perr = 1'b0;
        ez.ferr = 1'b1;
        ez.brk  = 1'b1;
        push_exp(0, ez);
        hold(0, 1'b0, 40 * BIT);
        check("a5_one_frame", n_val_a - base, 1);
        check("a5_wait_busy", busy_a, 1);
        hold(0, 1'b1, 2 * BIT);
        check("a5_still_one", n_val_a - base, 1);
        check("a5_idle", busy_a, 0);

        // 6: reset during data bit 4 of 0xC3 aborts it; 0x5A then received.
        base = n_val_a;
        hold(0, 1'b0, BIT);
        hold(0, 1'b1, BIT);
        hold(0, 1'b1, BIT);
        hold(0, 1'b0, BIT);
        hold(0, 1'b0, BIT);
        hold(0, 1'b0, 8);
        check("a6_busy_before", busy_a, 1);
        reset = 1'b1;
        #1;
        check("a6_rst_busy", busy_a, 0);
        check("a6_rst_valid", valid_a, 0);
        check("a6_rst_flags_a", {perr_a, ferr_a, brk_a}, 0);
        check("a6_rst_data_a", rx_data_a, 0);
        check("a6_rst_data_b", rx_data_b, 0);
        check("a6_rst_data_c", rx_data_c, 0);
        check("a6_rst_flags_b", {perr_b, ferr_b, brk_b}, 0);
        @(negedge clk);
        hold(0, 1'b0, 7);
        hold(0, 1'b0, BIT);
        hold(0, 1'b1, BIT);
        hold(0, 1'b1, BIT);
        hold(0, 1'b1, BIT);
        reset = 1'b0;
        hold(0, 1'b1, 2 * BIT);
        check("a6_no_valid", n_val_a - base, 0);
        send_frame(0, 9'h5A, 8, 0, 1'b0, 1, 1'b1, 1'b1, 1'b1);
        hold(0, 1'b1, 2 * BIT);
        check("a6_after_count", n_val_a - base, 1);

        check("a_pending", q_a.size(), 0);
        check("b_pending", q_b.size(), 0);
        check("c_pending", q_c.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
